// File: rtl/l2_bank_array_ctrl.sv
// l2_bank_array_ctrl: per-port private L2 banks with range checking, fixed-latency responses
// and a bulk zeroing sequencer.
module l2_bank_array_ctrl #(
    parameter int unsigned NB_BANKS    = 4,
    parameter int unsigned BANK_WORDS  = 32768,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter logic [31:0] BASE_ADDR   = 32'h1C01_0000,
    parameter int unsigned RD_LATENCY  = 1,
    parameter int unsigned INTERLEAVED = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           init_req_i,
    output logic                           init_done_o,
    input  logic [NB_BANKS-1:0]            req_i,
    input  logic [NB_BANKS*32-1:0]         add_i,
    input  logic [NB_BANKS-1:0]            wen_i,
    input  logic [NB_BANKS*DATA_WIDTH/8-1:0] be_i,
    input  logic [NB_BANKS*DATA_WIDTH-1:0] wdata_i,
    output logic [NB_BANKS-1:0]            gnt_o,
    output logic [NB_BANKS-1:0]            r_valid_o,
    output logic [NB_BANKS*DATA_WIDTH-1:0] r_rdata_o,
    output logic [NB_BANKS-1:0]            r_opc_o
);
    localparam int unsigned AW  = $clog2(BANK_WORDS);
    localparam int unsigned LNB = $clog2(NB_BANKS);
    localparam int unsigned BW  = DATA_WIDTH / 8;
    localparam int unsigned LO  = (INTERLEAVED != 0) ? 2 + LNB : 2;
    localparam int unsigned SH  = LO + AW;

    typedef enum logic [1:0] {IDLE, CLEAR, READY} state_e;

    state_e        state;
    logic [AW-1:0] cnt;

    assign gnt_o = req_i & {NB_BANKS{state != CLEAR}};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            cnt         <= '0;
            init_done_o <= 1'b0;
        end else if (state == CLEAR) begin
            cnt <= cnt + AW'(1);
            if (cnt == AW'(BANK_WORDS - 1)) begin
                state       <= READY;
                init_done_o <= 1'b1;
            end
        end else if (init_req_i) begin
            state       <= CLEAR;
            cnt         <= '0;
            init_done_o <= 1'b0;
        end
    end

    for (genvar i = 0; i < NB_BANKS; i++) begin : g_bank
        logic [31:0]           off;
        logic [AW-1:0]         idx;
        logic                  oor;
        logic [DATA_WIDTH-1:0] mem [BANK_WORDS];
        logic [DATA_WIDTH-1:0] dq  [RD_LATENCY];
        logic [RD_LATENCY-1:0] vq, oq, rq;

        assign off = add_i[i*32 +: 32] - BASE_ADDR;
        assign idx = off[LO +: AW];
        // Bits above the word index must match this port's window (bank 0 window when interleaved).
        assign oor = (INTERLEAVED != 0) ? ((off >> SH) != 32'd0) : ((off >> SH) != 32'(i));

        // Memory and data pipeline carry no reset; validity is tracked separately.
        always_ff @(posedge clk_i) begin
            if (state == CLEAR)
                mem[cnt] <= '0;
            else if (gnt_o[i] && !wen_i[i] && !oor)
                for (int b = 0; b < BW; b++)
                    if (be_i[i*BW + b])
                        mem[idx][b*8 +: 8] <= wdata_i[i*DATA_WIDTH + b*8 +: 8];
            dq[0] <= mem[idx];
            for (int s = 1; s < RD_LATENCY; s++)
                dq[s] <= dq[s-1];
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                vq <= '0;
                oq <= '0;
                rq <= '0;
            end else begin
                vq[0] <= gnt_o[i];
                oq[0] <= gnt_o[i] & oor;
                rq[0] <= gnt_o[i] & wen_i[i] & ~oor;
                for (int s = 1; s < RD_LATENCY; s++) begin
                    vq[s] <= vq[s-1];
                    oq[s] <= oq[s-1];
                    rq[s] <= rq[s-1];
                end
            end
        end

        assign r_valid_o[i] = vq[RD_LATENCY-1];
        assign r_opc_o[i]   = vq[RD_LATENCY-1] & oq[RD_LATENCY-1];
        assign r_rdata_o[i*DATA_WIDTH +: DATA_WIDTH] =
            (vq[RD_LATENCY-1] & rq[RD_LATENCY-1]) ? dq[RD_LATENCY-1] : '0;
    end
endmodule

// File: tb/tb_l2_bank_array_ctrl.sv
// tb_l2_bank_array_ctrl: directed vectors on a default-size instance and a small
// 16-word, 3-cycle-latency instance for pipelining and zeroing sequences.
module tb_l2_bank_array_ctrl;
    localparam logic [31:0] BASE = 32'h1C01_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic         a_init = 0, a_done;
    logic [3:0]   a_req = 0, a_wen = 0, a_gnt, a_rv, a_opc;
    logic [127:0] a_add = 0, a_wdata = 0, a_rdata;
    logic [15:0]  a_be = 0;

    logic         b_init = 0, b_done;
    logic [3:0]   b_req = 0, b_wen = 0, b_gnt, b_rv, b_opc;
    logic [127:0] b_add = 0, b_wdata = 0, b_rdata;
    logic [15:0]  b_be = 0;

    l2_bank_array_ctrl dut_a (
        .clk_i(clk), .rst_ni(rst_n), .init_req_i(a_init), .init_done_o(a_done),
        .req_i(a_req), .add_i(a_add), .wen_i(a_wen), .be_i(a_be), .wdata_i(a_wdata),
        .gnt_o(a_gnt), .r_valid_o(a_rv), .r_rdata_o(a_rdata), .r_opc_o(a_opc)
    );

    l2_bank_array_ctrl #(.BANK_WORDS(16), .RD_LATENCY(3)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .init_req_i(b_init), .init_done_o(b_done),
        .req_i(b_req), .add_i(b_add), .wen_i(b_wen), .be_i(b_be), .wdata_i(b_wdata),
        .gnt_o(b_gnt), .r_valid_o(b_rv), .r_rdata_o(b_rdata), .r_opc_o(b_opc)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        int          port;
        logic [31:0] addr;
        logic        wen;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_opc;
    } vec_t;

    vec_t vt[14];

    initial begin
        vt[0]  = '{1, 32'h1C01_0014, 1'b0, 4'hF, 32'hDEADBEEF, 32'h0,         1'b0};
        vt[1]  = '{1, 32'h1C01_0014, 1'b1, 4'hF, 32'h0,        32'hDEADBEEF,  1'b0};
        vt[2]  = '{2, 32'h1C01_0028, 1'b0, 4'hF, 32'h11223344, 32'h0,         1'b0};
        vt[3]  = '{2, 32'h1C01_0028, 1'b0, 4'h5, 32'hAABBCCDD, 32'h0,         1'b0};
        vt[4]  = '{2, 32'h1C01_0028, 1'b1, 4'hF, 32'h0,        32'h11BB33DD,  1'b0};
        vt[5]  = '{0, 32'h1C01_0000, 1'b0, 4'hF, 32'h55555555, 32'h0,         1'b0};
        vt[6]  = '{0, 32'h1C09_0000, 1'b0, 4'hF, 32'hCAFEF00D, 32'h0,         1'b1};
        vt[7]  = '{0, 32'h1C09_0000, 1'b1, 4'hF, 32'h0,        32'h0,         1'b1};
        vt[8]  = '{0, 32'h1C01_0000, 1'b1, 4'hF, 32'h0,        32'h55555555,  1'b0};
        vt[9]  = '{3, 32'h1C00_FFFC, 1'b1, 4'hF, 32'h0,        32'h0,         1'b1};
        vt[10] = '{1, 32'h1C01_0014, 1'b0, 4'h0, 32'hFFFFFFFF, 32'h0,         1'b0};
        vt[11] = '{1, 32'h1C01_0014, 1'b1, 4'hF, 32'h0,        32'hDEADBEEF,  1'b0};
        vt[12] = '{3, 32'h1C01_003C, 1'b0, 4'hF, 32'h12345678, 32'h0,         1'b0};
        vt[13] = '{3, 32'h1C01_003C, 1'b1, 4'hF, 32'h0,        32'h12345678,  1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_a_done", a_done, 0);
        chk("reset_a_valid", a_rv, 0);
        chk("reset_a_rdata", a_rdata, 0);
        chk("reset_a_opc", a_opc, 0);
        chk("reset_b_done", b_done, 0);
        chk("reset_b_valid", b_rv, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-request vectors, issued back to back on dut_a
        for (int k = 0; k < 14; k++) begin
            a_req = 4'b0001 << vt[k].port;
            a_wen[vt[k].port] = vt[k].wen;
            a_add[vt[k].port*32 +: 32] = vt[k].addr;
            a_be[vt[k].port*4 +: 4] = vt[k].be;
            a_wdata[vt[k].port*32 +: 32] = vt[k].wdata;
            #1;
            chk($sformatf("vec%0d_gnt", k), a_gnt, 4'b0001 << vt[k].port);
            @(posedge clk);
            #1;
            a_req = 0;
            chk($sformatf("vec%0d_valid", k), a_rv, 4'b0001 << vt[k].port);
            chk($sformatf("vec%0d_rdata", k), a_rdata, 128'(vt[k].exp_rdata) << (vt[k].port*32));
            chk($sformatf("vec%0d_opc", k), a_opc, 4'(vt[k].exp_opc) << vt[k].port);
        end

        // Read followed by a write to the same word: the read returns the old word
        a_req = 4'b0010; a_wen = 4'b0010; a_add[63:32] = 32'h1C01_0014;
        @(posedge clk);
        #1;
        a_wen = 4'b0000; a_be[7:4] = 4'hF; a_wdata[63:32] = 32'h0BADF00D;
        chk("rbw_read_old", a_rdata[63:32], 32'hDEADBEEF);
        @(posedge clk);
        #1;
        a_wen = 4'b0010;
        chk("rbw_write_resp", {a_rv, a_rdata[63:32]}, {4'b0010, 32'h0});
        @(posedge clk);
        #1;
        a_req = 0;
        chk("rbw_read_new", a_rdata[63:32], 32'h0BADF00D);

        // Latency 3: preload 4 words on port 0, then 4 consecutive reads
        for (int k = 0; k < 4; k++) begin
            b_req = 4'b0001; b_wen = 0; b_be = 16'h000F;
            b_add[31:0] = BASE + 32'(k*16); b_wdata[31:0] = 32'hA0 + 32'(k);
            @(posedge clk);
            #1;
        end
        b_req = 0;
        repeat (4) @(posedge clk);
        #1;
        for (int j = 0; j < 9; j++) begin
            if (j < 4) begin
                b_req = 4'b0001; b_wen = 4'b0001; b_add[31:0] = BASE + 32'(j*16);
            end else b_req = 0;
            @(posedge clk);
            #1;
            chk($sformatf("lat3_valid_e%0d", j+1), b_rv, (j+1 >= 3 && j+1 <= 6) ? 4'b0001 : 4'b0000);
            chk($sformatf("lat3_rdata_e%0d", j+1), b_rdata,
                (j+1 >= 3 && j+1 <= 6) ? 128'(32'hA0 + 32'(j-2)) : 128'h0);
        end

        // Init: a read granted in the entry cycle still drains during CLEAR
        b_init = 1; b_req = 4'b0001; b_wen = 4'b0001; b_add[31:0] = BASE;
        #1;
        chk("init_entry_gnt", b_gnt, 4'b0001);
        @(posedge clk);
        #1;
        b_init = 0; b_req = 4'hF; b_wen = 4'hF;
        for (int c = 1; c <= 16; c++) begin
            chk($sformatf("clear_gnt_c%0d", c), b_gnt, 4'h0);
            chk($sformatf("clear_done_c%0d", c), b_done, 1'b0);
            chk($sformatf("clear_valid_c%0d", c), b_rv, (c == 3) ? 4'b0001 : 4'b0000);
            if (c == 3) chk("clear_drain_rdata", b_rdata[31:0], 32'hA0);
            b_init = (c == 5);
            @(posedge clk);
            #1;
        end
        b_init = 0;
        chk("ready_gnt", b_gnt, 4'hF);
        chk("ready_done", b_done, 1'b1);
        b_req = 0;
        repeat (4) @(posedge clk);
        #1;
        for (int k = 0; k < 16; k++) begin
            b_req = 4'hF; b_wen = 4'hF;
            for (int p = 0; p < 4; p++) b_add[p*32 +: 32] = BASE + 32'(k*16 + p*4);
            @(posedge clk);
            #1;
            b_req = 0;
            repeat (2) @(posedge clk);
            #1;
            chk($sformatf("zero_valid_w%0d", k), {b_rv, b_opc}, {4'hF, 4'h0});
            chk($sformatf("zero_rdata_w%0d", k), b_rdata, 128'h0);
        end

        // Reset while the counter is at 5
        b_init = 1;
        @(posedge clk);
        #1;
        b_init = 0; b_req = 4'hF;
        chk("reinit_done_drop", b_done, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("midclear_gnt", b_gnt, 4'h0);
        rst_n = 1'b0;
        #1;
        chk("rst_gnt", b_gnt, 4'hF);
        chk("rst_done", b_done, 1'b0);
        chk("rst_valid", b_rv, 4'h0);
        #2 rst_n = 1'b1;
        #1;
        chk("rel_gnt", b_gnt, 4'hF);
        chk("rel_done", b_done, 1'b0);
        b_req = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("rel_done_stays_idle", b_done, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/l2_bank_array_ctrl.md
L2_BANK_ARRAY_CTRL -- requirements
Module: l2_bank_array_ctrl

Interface
REQ-001 SHALL have parameter NB_BANKS, default 4: bank/port count; power of two, 1..16.
REQ-002 SHALL have parameter BANK_WORDS, default 32768: words per bank; power of two >= 16; AW = log2(BANK_WORDS).
REQ-003 SHALL have parameter DATA_WIDTH, default 32: word width; multiple of 8; BW = DATA_WIDTH/8.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h1C01_0000: byte base address subtracted from every request.
REQ-005 SHALL have parameter RD_LATENCY, default 1: cycles from grant to response; legal range 1..3.
REQ-006 SHALL have parameter INTERLEAVED, default 1: 1 = word-interleaved banks, 0 = contiguous banks.
REQ-007 SHALL have port clk_i, input, 1: clock, rising edge.
REQ-008 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-009 SHALL have port init_req_i, input, 1: request to zero all banks.
REQ-010 SHALL have port init_done_o, output, 1: zeroing completed.
REQ-011 SHALL have port req_i, input, NB_BANKS: per-port request.
REQ-012 SHALL have port add_i, input, NB_BANKS*32: per-port byte address.
REQ-013 SHALL have port wen_i, input, NB_BANKS: per-port access type; 1 = read, 0 = write.
REQ-014 SHALL have port be_i, input, NB_BANKS*BW: per-port byte enables, active-high.
REQ-015 SHALL have port wdata_i, input, NB_BANKS*DATA_WIDTH: per-port write data.
REQ-016 SHALL have port gnt_o, output, NB_BANKS: per-port grant.
REQ-017 SHALL have port r_valid_o, output, NB_BANKS: per-port response valid.
REQ-018 SHALL have port r_rdata_o, output, NB_BANKS*DATA_WIDTH: per-port read data.
REQ-019 SHALL have port r_opc_o, output, NB_BANKS: per-port error flag, qualified by r_valid_o.

Function
REQ-020 SHALL combinationally drive gnt_o[i] = req_i[i] & (state != CLEAR).
REQ-021 SHALL compute the offset as add_i[i] - BASE_ADDR, modulo 2^32.
REQ-022 SHALL, when INTERLEAVED=1, use word index offset[AW+1+log2(NB_BANKS) : 2+log2(NB_BANKS)], and flag out-of-range when offset >= NB_BANKS*BANK_WORDS*4.
REQ-023 SHALL, when INTERLEAVED=0, use word index offset[AW+1:2] relative to bank window i*BANK_WORDS*4, and flag out-of-range when offset lies outside [i*BANK_WORDS*4, (i+1)*BANK_WORDS*4).
REQ-024 SHALL, for a granted write in range, update exactly the bytes with be_i set; all other bytes are unchanged.
REQ-025 SHALL suppress the memory write for an out-of-range request.
REQ-026 SHALL assert r_valid_o[i] for one cycle exactly RD_LATENCY cycles after each granted request, read or write.
REQ-027 SHALL accept back-to-back requests every cycle on each port, with no bubbles.
REQ-028 SHALL drive r_rdata_o as follows: in-range read = stored word; write = 0; out-of-range = 0.
REQ-029 SHALL set r_opc_o = 1 with r_valid_o for out-of-range requests, and 0 otherwise.
REQ-030 SHALL hold r_rdata_o and r_opc_o at 0 whenever r_valid_o = 0.
REQ-031 SHALL return the word as it was before a write to the same address that is granted in the same or a later cycle.
REQ-032 SHALL implement an FSM with states IDLE, CLEAR and READY.
REQ-033 SHALL enter IDLE on reset; in IDLE, accesses are allowed and contents are undefined.
REQ-034 SHALL transition IDLE or READY to CLEAR on init_req_i = 1; the counter loads 0 and init_done_o drops to 0 in the same edge.
REQ-035 SHALL, in CLEAR, write 0 to word [counter] of every bank each cycle, then increment the counter.
REQ-036 SHALL transition CLEAR to READY after the cycle with counter = BANK_WORDS-1, so CLEAR lasts exactly BANK_WORDS cycles.
REQ-037 SHALL set init_done_o = 1 from the first READY cycle.
REQ-038 SHALL ignore init_req_i while in CLEAR.
REQ-039 SHALL still deliver responses for requests granted before CLEAR entry, draining the response pipeline.

Reset
REQ-040 SHALL, on rst_ni = 0, asynchronously force the following: state = IDLE, counter = 0, init_done_o = 0, r_valid_o = 0, r_rdata_o = 0, r_opc_o = 0, and the pipeline is flushed.
REQ-041 SHALL, on reset during CLEAR, abort zeroing; the state returns to IDLE and partial contents are undefined.
REQ-042 SHALL not reset memory contents.

Verification
REQ-043 SHALL cover interleaved write then read: NB_BANKS=4, RD_LATENCY=1; port 1 writes 32'hDEADBEEF to 0x1C01_0014, be=4'hF, then reads it -> r_valid one cycle after each grant; read returns 32'hDEADBEEF, r_opc=0.
REQ-044 SHALL cover byte enables: a word holds 32'h11223344; write 32'hAABBCCDD with be=4'b0101 -> read returns 32'h11BB33DD.
REQ-045 SHALL cover out-of-range: read at 0x1C09_0000 (INTERLEAVED=1, 4x32768 words) -> r_valid=1, r_opc=1, rdata=0; a prior write there leaves all banks unchanged.
REQ-046 SHALL cover latency and throughput: RD_LATENCY=3, reads on 4 consecutive cycles -> 4 consecutive r_valid pulses starting 3 cycles after the first grant, with data in order.
REQ-047 SHALL cover init: BANK_WORDS=16, pulse init_req_i -> gnt_o=0 for 16 cycles, init_done_o=1 on cycle 17, and all words read 0; a second init_req_i during CLEAR has no effect.
REQ-048 SHALL cover reset mid-CLEAR: assert rst_ni=0 at counter=5 -> state IDLE, init_done_o=0, r_valid_o=0, and gnt_o follows req_i immediately after release.
